// File: rtl/countdown_digit_ctrl.sv
// rtl/countdown_digit_ctrl.sv - digit sprite countdown sequencer with 2-cycle keyed pixel pipeline
module countdown_digit_ctrl #(
    parameter int START_VAL     = 5,
    parameter int TICKS_PER_SEC = 60,
    parameter int X0            = 304,
    parameter int Y0            = 228,
    parameter int KEY           = 391
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] sprite_pix,
    output logic [3:0] digit,
    output logic [4:0] sprite_row,
    output logic [4:0] sprite_col,
    output logic       pix_on,
    output logic [9:0] pix_rgb,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse
);
    localparam int TW = $clog2(TICKS_PER_SEC) + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    DIGIT_START = 4'(START_VAL);
    localparam bit            START_ZERO  = (START_VAL == 0);
    localparam logic [9:0]    X0_W        = 10'(X0);
    localparam logic [9:0]    Y0_W        = 10'(Y0);
    localparam logic [10:0]   X_LO        = 11'(X0);
    localparam logic [10:0]   X_HI        = 11'(X0 + 32);
    localparam logic [10:0]   Y_LO        = 11'(Y0);
    localparam logic [10:0]   Y_HI        = 11'(Y0 + 24);
    localparam logic [9:0]    KEY_W       = 10'(KEY);

    logic [1:0]    state, state_n;
    logic [3:0]    digit_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic          pulse_n;
    logic          fc_q, fe;
    logic          in_box, in_box_q, pix_hit;
    logic [4:0]    rx, ry;

    assign fe = frame_clk & ~fc_q;

    always_comb begin
        state_n = state;
        digit_n = digit;
        tick_n  = tick_cnt;
        pulse_n = 1'b0;
        if (start) begin
            digit_n = DIGIT_START;
            tick_n  = '0;
            if (START_ZERO) begin
                state_n = S_EXPIRED;
                pulse_n = 1'b1;
            end else begin
                state_n = S_RUN;
            end
        end else begin
            case (state)
                S_RUN: begin
                    // pause wins over a coincident frame edge
                    if (pause) begin
                        state_n = S_PAUSE;
                    end else if (fe) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_n  = '0;
                            digit_n = digit - 4'd1;
                            if (digit == 4'd1) begin
                                state_n = S_EXPIRED;
                                pulse_n = 1'b1;
                            end
                        end else begin
                            tick_n = tick_cnt + TW'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (!pause) state_n = S_RUN;
                end
                default: ;
            endcase
        end
    end

    // 11-bit compares keep X0+32 / Y0+24 from wrapping
    assign in_box = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                    ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
    assign rx      = 5'(DrawX - X0_W);
    assign ry      = 5'(DrawY - Y0_W);
    assign pix_hit = in_box_q && (state != S_IDLE) && (sprite_pix != KEY_W);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_q         <= 1'b1;
            state        <= S_IDLE;
            digit        <= '0;
            tick_cnt     <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
            in_box_q     <= 1'b0;
            sprite_row   <= '0;
            sprite_col   <= '0;
            pix_on       <= 1'b0;
            pix_rgb      <= '0;
        end else begin
            fc_q         <= frame_clk;
            state        <= state_n;
            digit        <= digit_n;
            tick_cnt     <= tick_n;
            running      <= (state_n == S_RUN) || (state_n == S_PAUSE);
            expired      <= (state_n == S_EXPIRED);
            expire_pulse <= pulse_n;
            in_box_q     <= in_box;
            sprite_row   <= in_box ? ry : 5'd0;
            sprite_col   <= in_box ? rx : 5'd0;
            pix_on       <= pix_hit;
            pix_rgb      <= pix_hit ? sprite_pix : 10'd0;
        end
    end
endmodule

// File: tb/tb_countdown_digit_ctrl.sv
// tb/tb_countdown_digit_ctrl.sv - self-checking bench for countdown_digit_ctrl
module tb_countdown_digit_ctrl;
    localparam int TPS = 3, SV = 5, XL = 304, YT = 228, KEYV = 391, OPAQUE = 430;

    logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, start = 1'b0, start0 = 1'b0, pause = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [9:0] sprite_pix, sprite_pix0, pix_rgb, pix_rgb0;
    logic [3:0] digit, digit0;
    logic [4:0] sprite_row, sprite_col, sprite_row0, sprite_col0;
    logic       pix_on, pix_on0, running, running0, expired, expired0, expire_pulse, expire_pulse0;

    int tests = 0, fails = 0, pulse_seen = 0, hits = 0;

    bit m_fc, m_active, m_paused, m_pulse, m_ib, m_pix;
    int m_cnt, m_col, m_row, m_rgb;

    always #5 Clk = ~Clk;

    assign sprite_pix  = (sprite_col  == 5'd2) ? 10'd430 : 10'd391;
    assign sprite_pix0 = (sprite_col0 == 5'd2) ? 10'd430 : 10'd391;

    countdown_digit_ctrl #(.START_VAL(SV), .TICKS_PER_SEC(TPS), .X0(XL), .Y0(YT), .KEY(KEYV)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .pause(pause),
        .DrawX(DrawX), .DrawY(DrawY), .sprite_pix(sprite_pix), .digit(digit),
        .sprite_row(sprite_row), .sprite_col(sprite_col), .pix_on(pix_on), .pix_rgb(pix_rgb),
        .running(running), .expired(expired), .expire_pulse(expire_pulse));

    countdown_digit_ctrl #(.START_VAL(0), .TICKS_PER_SEC(TPS), .X0(XL), .Y0(YT), .KEY(KEYV)) dut0 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start0), .pause(pause),
        .DrawX(DrawX), .DrawY(DrawY), .sprite_pix(sprite_pix0), .digit(digit0),
        .sprite_row(sprite_row0), .sprite_col(sprite_col0), .pix_on(pix_on0), .pix_rgb(pix_rgb0),
        .running(running0), .expired(expired0), .expire_pulse(expire_pulse0));

    // Reference: the countdown is the number of counted frame edges since start
    function automatic bit m_expired();
        return m_active && (m_cnt >= SV * TPS);
    endfunction

    function automatic int m_digit();
        return m_active ? SV - m_cnt / TPS : 0;
    endfunction

    task automatic model_step();
        bit fe, was_exp;
        int rom;
        if (Reset) begin
            m_fc = 1; m_active = 0; m_paused = 0; m_cnt = 0; m_pulse = 0;
            m_ib = 0; m_col = 0; m_row = 0; m_pix = 0; m_rgb = 0;
        end else begin
            fe   = frame_clk && !m_fc;
            m_fc = frame_clk;
            rom   = (m_col == 2) ? OPAQUE : KEYV;
            m_pix = m_ib && m_active && (rom != KEYV);
            m_rgb = m_pix ? rom : 0;
            m_ib  = (DrawX >= XL) && (DrawX < XL + 32) && (DrawY >= YT) && (DrawY < YT + 24);
            m_col = m_ib ? int'(DrawX) - XL : 0;
            m_row = m_ib ? int'(DrawY) - YT : 0;
            was_exp = m_expired();
            if (start) begin
                m_active = 1; m_paused = 0; m_cnt = 0;
            end else if (m_active && !was_exp) begin
                if (m_paused) m_paused = pause;
                else if (pause) m_paused = 1;
                else if (fe) m_cnt++;
            end
            m_pulse = !was_exp && m_expired();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("digit", 32'(digit), m_digit());
        check("running", 32'(running), 32'(m_active && !m_expired()));
        check("expired", 32'(expired), 32'(m_expired()));
        check("expire_pulse", 32'(expire_pulse), 32'(m_pulse));
        check("sprite_col", 32'(sprite_col), m_col);
        check("sprite_row", 32'(sprite_row), m_row);
        check("pix_on", 32'(pix_on), 32'(m_pix));
        check("pix_rgb", 32'(pix_rgb), m_rgb);
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        if (expire_pulse === 1'b1) pulse_seen++;
        if (pix_on === 1'b1) hits++;
        check_all();
    endtask

    task automatic fe_pulse();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset state
        Reset = 1'b1;
        tick();
        tick();
        check("rst_digit", 32'(digit), 0);
        check("rst_running", 32'(running), 0);
        check("rst_expired", 32'(expired), 0);
        check("rst_pix_on", 32'(pix_on), 0);
        Reset = 1'b0;
        tick();

        // full countdown 5..0, one step every third frame edge
        do_start();
        check("start_digit", 32'(digit), 5);
        pulse_seen = 0;
        for (int k = 1; k <= 15; k++) begin
            fe_pulse();
            check("count_digit", 32'(digit), 32'(5 - k / 3));
        end
        check("expired_after15", 32'(expired), 1);
        check("running_after15", 32'(running), 0);
        repeat (3) tick();
        check("expire_pulse_once", 32'(pulse_seen), 1);

        // pause at digit 3 with one tick already counted
        do_start();
        repeat (7) fe_pulse();
        check("pre_pause_digit", 32'(digit), 3);
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fe_pulse();
            check("paused_digit", 32'(digit), 3);
        end
        pause = 1'b0;
        tick();
        fe_pulse();
        check("resume_fe1", 32'(digit), 3);
        fe_pulse();
        check("resume_fe2", 32'(digit), 2);

        // start + pause + frame edge together while paused
        pause = 1'b1;
        tick();
        start = 1'b1;
        frame_clk = 1'b1;
        tick();
        start = 1'b0;
        pause = 1'b0;
        frame_clk = 1'b0;
        check("restart_digit", 32'(digit), 5);
        check("restart_running", 32'(running), 1);
        tick();
        repeat (2) fe_pulse();
        check("restart_tick0_a", 32'(digit), 5);
        fe_pulse();
        check("restart_tick0_b", 32'(digit), 4);

        // frame_clk held high across reset release
        frame_clk = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        do_start();
        repeat (100) tick();
        check("no_false_edge", 32'(digit), 5);
        frame_clk = 1'b0;
        tick();
        repeat (2) fe_pulse();
        check("held_high_tick_a", 32'(digit), 5);
        fe_pulse();
        check("held_high_tick_b", 32'(digit), 4);

        // DrawX sweep across the sprite box
        do_start();
        DrawY = 10'd230;
        hits = 0;
        for (int x = 300; x <= 340; x++) begin
            DrawX = 10'(x);
            tick();
            if (x == 306) begin
                check("sweep_col", 32'(sprite_col), 2);
                check("sweep_row", 32'(sprite_row), 2);
            end
            if (x == 307) begin
                check("sweep_pix_on", 32'(pix_on), 1);
                check("sweep_pix_rgb", 32'(pix_rgb), 430);
            end
            if (x - 1 < 304 || x - 1 > 335) check("sweep_outside", 32'(pix_on), 0);
        end
        DrawX = 10'd0;
        tick();
        tick();
        check("sweep_hits", 32'(hits), 1);

        // START_VAL of zero expires immediately
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("z_expired", 32'(expired0), 1);
        check("z_pulse", 32'(expire_pulse0), 1);
        check("z_running", 32'(running0), 0);
        check("z_digit", 32'(digit0), 0);
        tick();
        check("z_pulse_gone", 32'(expire_pulse0), 0);
        check("z_expired_hold", 32'(expired0), 1);

        // reset mid-countdown
        do_start();
        repeat (3) fe_pulse();
        check("mid_digit", 32'(digit), 4);
        DrawX = 10'd306;
        DrawY = 10'd230;
        Reset = 1'b1;
        tick();
        check("mid_rst_digit", 32'(digit), 0);
        check("mid_rst_running", 32'(running), 0);
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            DrawX = 10'(300 + $urandom_range(0, 40));
            DrawY = 10'(225 + $urandom_range(0, 30));
            tick();
            check("idle_pix_off", 32'(pix_on), 0);
        end

        // randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            start = ($urandom_range(0, 250) == 0);
            Reset = ($urandom_range(0, 900) == 0);
            DrawX = 10'(296 + $urandom_range(0, 47));
            DrawY = 10'(220 + $urandom_range(0, 35));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/countdown_digit_ctrl.md
Name: countdown_digit_ctrl

Overview:
- Sequences the 32x24 digit sprite ROMs (digits 0-9, 10-bit colour words, background key 391) for the Bomberman bomb and round countdown overlay.
- Counts down one digit per second, measured in video frames.
- Maps the current VGA scan position to sprite row and column addresses, and returns the keyed pixel to the colour mapper.
- Sits between the frame-clock and VGA controller and the digit-ROM mux.

Parameters:
- START_VAL, 5, digit loaded on start (0-9).
- TICKS_PER_SEC, 60, frame_clk rising edges per digit decrement (>=1).
- X0, 304, left edge of the sprite box in DrawX pixels.
- Y0, 228, top edge of the sprite box in DrawY pixels.
- KEY, 391, transparent colour value.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  vsync-derived level signal, synchronous to Clk.
- start  in  1  one-cycle pulse; loads START_VAL and begins the countdown.
- pause  in  1  level; freezes the countdown while high.
- DrawX  in  10  current scan column.
- DrawY  in  10  current scan row.
- sprite_pix  in  10  combinational ROM output for (digit, sprite_row, sprite_col).
- digit  out  4  digit currently selected for the ROM mux.
- sprite_row  out  5  ROM row address, 0-23.
- sprite_col  out  5  ROM column address, 0-31.
- pix_on  out  1  overlay pixel valid and opaque.
- pix_rgb  out  10  overlay colour; 0 when pix_on=0.
- running  out  1  high in the RUN or PAUSE state.
- expired  out  1  high in the EXPIRED state.
- expire_pulse  out  1  one-cycle pulse on entry to EXPIRED.

Behaviour:
- Frame edge: fe = frame_clk & ~fc_q, where fc_q is frame_clk delayed by one Clk cycle.
  - fc_q resets to 1, so a high frame_clk at reset release does not produce a false edge.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- Reset values: state=IDLE, digit=0, tick_cnt=0, sprite_row=0, sprite_col=0, pix_on=0, pix_rgb=0, running=0, expired=0, expire_pulse=0.
- start, from any state, takes priority over pause and fe in the same cycle:
  - digit=START_VAL, tick_cnt=0.
  - Next state is RUN, or EXPIRED with expire_pulse=1 when START_VAL==0.
- RUN:
  - pause=1 with no start: go to PAUSE; tick_cnt holds. A fe in that same cycle is ignored.
  - fe with tick_cnt<TICKS_PER_SEC-1: tick_cnt+1.
  - fe with tick_cnt==TICKS_PER_SEC-1: tick_cnt=0 and digit-1.
  - If that decrement makes digit 0: next state EXPIRED and expire_pulse=1 in the following cycle only.
- PAUSE: fe is ignored. pause=0 returns to RUN with tick_cnt preserved.
- IDLE and EXPIRED: fe and pause are ignored. digit holds; it is 0 in EXPIRED.
- Width rules:
  - tick_cnt is $clog2(TICKS_PER_SEC)+1 bits.
  - Box coordinates are computed as rx=DrawX-X0 and ry=DrawY-Y0 in 10-bit unsigned arithmetic.
  - in_box = (DrawX>=X0)&&(DrawX<X0+32)&&(DrawY>=Y0)&&(DrawY<Y0+24). Comparisons are done at 11-bit width, so X0+32 does not wrap.
- Pixel pipeline, fixed 2-cycle latency:
  - Cycle N: DrawX and DrawY are sampled.
  - Cycle N+1: sprite_row=ry[4:0] and sprite_col=rx[4:0] are registered. in_box_q is registered. Both addresses are forced to 0 when out of the box.
  - Cycle N+2: pix_on = in_box_q && (state!=IDLE) && (sprite_pix!=KEY). pix_rgb = sprite_pix when pix_on, else 0.
- Digit changes occur only on fe, which falls in vertical blanking, so there is no mid-frame tearing. The sole exception is start, which applies immediately.
- Reset asserted mid-countdown returns to IDLE on the next edge. Any expire_pulse in flight is cancelled.

Test Plan:
- Reset, then start with TICKS_PER_SEC=3 and START_VAL=5; apply 15 fe pulses.
  - digit steps 5,4,3,2,1,0, one step every 3rd fe.
  - expired=1 after the 15th fe, and expire_pulse is high for exactly 1 cycle.
- In RUN at digit=3 with tick_cnt=1, raise pause for 10 fe, then drop it.
  - digit stays 3 throughout the pause.
  - The decrement to 2 occurs on the 2nd fe after release.
- Assert start, pause and fe in the same cycle while in PAUSE at digit=2.
  - state=RUN, digit=5, tick_cnt=0.
- Hold frame_clk high through reset release, then keep it high for 100 cycles.
  - No fe is generated; tick_cnt stays 0.
- Sweep DrawX 300..340 on DrawY=230 in RUN with digit=5, with a model ROM returning 430 at col 2 and 391 elsewhere.
  - sprite_col=2 and sprite_row=2 one cycle after DrawX=306.
  - pix_on=1 and pix_rgb=430 two cycles after DrawX=306, and only for that pixel.
  - pix_on=0 whenever DrawX<304 or DrawX>335.
- With START_VAL=0, pulse start.
  - EXPIRED on the next cycle, expire_pulse=1 once, running=0.
- Assert Reset mid-countdown at digit=4.
  - IDLE with digit=0 next cycle; pix_on=0 for any DrawX and DrawY.
